ecc_apb_cmd_master: RTL and testbench

APB command master that sits directly upstream of the ECC encoder/decoder and drives its APB slave port. It accepts one ECC command per valid/ready handshake and performs the four register writes: DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL (the CTRL write is always last). It then waits for operation_done, captures data_out and num_of_errors, and returns them on a valid/ready response port. A watchdog timer bounds the wait.

---
 rtl/ecc_apb_cmd_master.sv | 188 ++++++++++++++++++
 tb/tb_ecc_apb_cmd_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_apb_cmd_master.sv
// APB command master for the ECC block: writes DATA_IN, CODEWORD_WIDTH, NOISE, CTRL,
// then waits (watchdog-bounded) for operation_done and returns the result on a valid/ready port.
module ecc_apb_cmd_master #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_ctrl,
    input  logic [AMBA_WORD-1:0]       cmd_data,
    input  logic [1:0]                 cmd_width,
    input  logic [AMBA_WORD-1:0]       cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic                       rsp_timeout,
    output logic                       busy
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t                       state_q, state_d;
    logic [1:0]                   idx_q, idx_d;
    logic [15:0]                  timer_q, timer_d;
    logic                         accept;

    logic [1:0]                   ctrl_q, width_q;
    logic [AMBA_WORD-1:0]         data_q, noise_q;
    logic [1:0]                   ctrl_f, width_f;
    logic [AMBA_WORD-1:0]         data_f, noise_f;

    logic                         psel_d, penable_d;
    logic [AMBA_ADDR_WIDTH-1:0]   paddr_d;
    logic [AMBA_WORD-1:0]         pwdata_d;
    logic [DATA_WIDTH-1:0]        rsp_data_d;
    logic [1:0]                   rsp_errors_d;
    logic                         rsp_timeout_d;

    // Index order is the write order; CTRL (offset 0) must be the final write.
    function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    reg_addr = BASE_ADDR + AMBA_ADDR_WIDTH'(4);
            2'd1:    reg_addr = BASE_ADDR + AMBA_ADDR_WIDTH'(8);
            2'd2:    reg_addr = BASE_ADDR + AMBA_ADDR_WIDTH'(12);
            default: reg_addr = BASE_ADDR;
        endcase
    endfunction

    function automatic logic [AMBA_WORD-1:0] reg_wdata(
        input logic [1:0]           idx,
        input logic [1:0]           ctrl,
        input logic [AMBA_WORD-1:0] data,
        input logic [1:0]           width,
        input logic [AMBA_WORD-1:0] noise
    );
        case (idx)
            2'd0:    reg_wdata = data;
            2'd1:    reg_wdata = AMBA_WORD'(width);
            2'd2:    reg_wdata = noise;
            default: reg_wdata = AMBA_WORD'(ctrl);
        endcase
    endfunction

    // On the accepting edge the first SETUP must already carry the new command's fields.
    assign ctrl_f  = accept ? cmd_ctrl  : ctrl_q;
    assign data_f  = accept ? cmd_data  : data_q;
    assign width_f = accept ? cmd_width : width_q;
    assign noise_f = accept ? cmd_noise : noise_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        accept        = 1'b0;
        rsp_data_d    = rsp_data;
        rsp_errors_d  = rsp_errors;
        rsp_timeout_d = rsp_timeout;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    idx_d   = 2'd0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = SETUP;
                end else begin
                    timer_d = '0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (operation_done) begin
                    rsp_data_d    = data_out;
                    rsp_errors_d  = num_of_errors;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timer_q >= TIMEOUT_LIM) begin
                    rsp_data_d    = '0;
                    rsp_errors_d  = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else if (timer_q != 16'hFFFF) begin
                    timer_d = timer_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        paddr_d   = '0;
        pwdata_d  = '0;
        if (psel_d) begin
            paddr_d  = reg_addr(idx_d);
            pwdata_d = reg_wdata(idx_d, ctrl_f, data_f, width_f, noise_f);
        end
    end

    // Registered outputs are loaded from next-state values so every port is a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            cmd_ready   <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_errors  <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            cmd_ready   <= (state_d == IDLE);
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            PWRITE      <= psel_d;
            PADDR       <= paddr_d;
            PWDATA      <= pwdata_d;
            rsp_valid   <= (state_d == RESP);
            rsp_data    <= rsp_data_d;
            rsp_errors  <= rsp_errors_d;
            rsp_timeout <= rsp_timeout_d;
            busy        <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ctrl_q  <= cmd_ctrl;
            data_q  <= cmd_data;
            width_q <= cmd_width;
            noise_q <= cmd_noise;
        end
    end

endmodule

// File: tb/tb_ecc_apb_cmd_master.sv
// Scoreboard bench for ecc_apb_cmd_master: expected APB writes and responses are queued
// when a command is issued and popped as the DUT performs them.
module tb_ecc_apb_cmd_master;

    localparam logic [19:0] BASE = 20'h04000;

    typedef struct packed { logic [19:0] addr; logic [31:0] data; } apb_t;
    typedef struct packed { logic [31:0] data; logic [1:0] err; logic tout; } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ctrl = '0;
    logic [31:0] cmd_data = '0;
    logic [1:0]  cmd_width = '0;
    logic [31:0] cmd_noise = '0;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic        operation_done = 1'b0;
    logic [31:0] data_out = '0;
    logic [1:0]  num_of_errors = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_errors;
    logic        rsp_timeout;
    logic        busy;

    int total = 0;
    int bad   = 0;

    apb_t exp_apb[$];
    rsp_t exp_rsp[$];

    ecc_apb_cmd_master #(
        .DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32),
        .BASE_ADDR(BASE), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ctrl(cmd_ctrl), .cmd_data(cmd_data), .cmd_width(cmd_width), .cmd_noise(cmd_noise),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_errors(rsp_errors), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_exp(input logic [1:0] c, input logic [31:0] d, input logic [1:0] w,
                            input logic [31:0] n, input logic [31:0] rd, input logic [1:0] re,
                            input logic rt);
        exp_apb.push_back('{addr: BASE + 20'h4, data: d});
        exp_apb.push_back('{addr: BASE + 20'h8, data: {30'd0, w}});
        exp_apb.push_back('{addr: BASE + 20'hC, data: n});
        exp_apb.push_back('{addr: BASE,         data: {30'd0, c}});
        exp_rsp.push_back('{data: rd, err: re, tout: rt});
    endtask

    // Returns in cycle 1 of the accepted command (just after the accepting edge).
    task automatic send_cmd(input logic [1:0] c, input logic [31:0] d, input logic [1:0] w,
                            input logic [31:0] n, input logic [31:0] rd, input logic [1:0] re,
                            input logic rt);
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        push_exp(c, d, w, n, rd, re, rt);
        cmd_valid = 1'b1;
        cmd_ctrl  = c;
        cmd_data  = d;
        cmd_width = w;
        cmd_noise = n;
        tick();
        cmd_valid = 1'b0;
        cmd_ctrl  = ~c;
        cmd_data  = ~d;
        cmd_width = ~w;
        cmd_noise = ~n;
        check("setup_c1", 64'({PSEL, PENABLE, PWRITE}), 64'b101);
        check("setup_c1_addr", 64'(PADDR), 64'(BASE + 20'h4));
    endtask

    // APB monitor: idle bus must be all-zero; every ACCESS cycle consumes one expected write.
    initial begin
        apb_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (!PSEL) begin
                    check("apb_idle", 64'({PADDR, PWDATA, PWRITE, PENABLE}), 64'd0);
                end else if (PENABLE) begin
                    if (exp_apb.size() == 0) begin
                        check("apb_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_apb.pop_front();
                        check("apb_addr", 64'(PADDR), 64'(e.addr));
                        check("apb_wdata", 64'(PWDATA), 64'(e.data));
                        check("apb_pwrite", 64'(PWRITE), 64'd1);
                    end
                end
            end
        end
    end

    // Response monitor: held responses must stay stable; handshakes pop the scoreboard.
    initial begin
        rsp_t e;
        logic pv = 1'b0, phs = 1'b0, pt = 1'b0;
        logic [31:0] pd = '0;
        logic [1:0]  pe = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                pv = 1'b0;
            end else begin
                if (rsp_valid && pv && !phs) begin
                    check("rsp_hold_data", 64'(rsp_data), 64'(pd));
                    check("rsp_hold_err", 64'(rsp_errors), 64'(pe));
                    check("rsp_hold_tout", 64'(rsp_timeout), 64'(pt));
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_rsp.size() == 0) begin
                        check("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_rsp.pop_front();
                        check("rsp_data", 64'(rsp_data), 64'(e.data));
                        check("rsp_errors", 64'(rsp_errors), 64'(e.err));
                        check("rsp_timeout", 64'(rsp_timeout), 64'(e.tout));
                    end
                end
                pv  = rsp_valid;
                phs = rsp_valid && rsp_ready;
                pd  = rsp_data;
                pe  = rsp_errors;
                pt  = rsp_timeout;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_apb", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_data, rsp_errors, rsp_timeout, busy}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("rel_cmd_ready_lo", 64'(cmd_ready), 64'd0);
        tick();
        check("rel_cmd_ready_hi", 64'(cmd_ready), 64'd1);

        // Encode, done sampled two cycles into WAIT_DONE
        send_cmd(2'd0, 32'h0000_00A5, 2'd0, 32'h0, 32'h0000_01A5, 2'd0, 1'b0);
        ticks(7);
        check("enc_ctrl_access", 64'({PSEL, PENABLE, PADDR}), 64'({2'b11, BASE}));
        tick();
        check("enc_wait_bus", 64'({PSEL, busy, cmd_ready}), 64'b010);
        ticks(2);
        data_out = 32'h0000_01A5; num_of_errors = 2'd0; operation_done = 1'b1;
        check("enc_rsp_not_yet", 64'(rsp_valid), 64'd0);
        tick();
        operation_done = 1'b0;
        check("enc_rsp_valid", 64'(rsp_valid), 64'd1);
        tick();
        check("enc_rsp_drop", 64'({rsp_valid, cmd_ready, busy}), 64'b010);

        // Decode with one error, done on the first WAIT_DONE cycle
        send_cmd(2'd1, 32'h0000_1234, 2'd1, 32'h0000_0004, 32'h1234_5678, 2'd1, 1'b0);
        ticks(8);
        data_out = 32'h1234_5678; num_of_errors = 2'd1; operation_done = 1'b1;
        tick();
        operation_done = 1'b0;
        check("dec_rsp_valid", 64'(rsp_valid), 64'd1);
        tick();

        // Watchdog timeout with garbage on the result bus
        data_out = 32'hFFFF_FFFF; num_of_errors = 2'd3;
        send_cmd(2'd2, 32'hDEAD_BEEF, 2'd2, 32'h0000_0001, 32'h0, 2'd0, 1'b1);
        ticks(12);
        check("to_not_yet", 64'(rsp_valid), 64'd0);
        tick();
        check("to_rsp_valid", 64'({rsp_valid, rsp_timeout}), 64'b11);
        tick();

        // Done arrives on the timeout cycle: done must win
        send_cmd(2'd0, 32'h0000_0055, 2'd3, 32'h0, 32'h0000_0ABC, 2'd2, 1'b0);
        ticks(12);
        data_out = 32'h0000_0ABC; num_of_errors = 2'd2; operation_done = 1'b1;
        tick();
        operation_done = 1'b0;
        check("tie_rsp_valid", 64'({rsp_valid, rsp_timeout}), 64'b10);
        tick();

        // Stray done during NOISE SETUP, then backpressure with a pending command
        send_cmd(2'd1, 32'h0000_0077, 2'd1, 32'h0000_0008, 32'h0000_0777, 2'd1, 1'b0);
        ticks(4);
        check("bp_noise_setup", 64'({PSEL, PENABLE, PADDR}), 64'({2'b10, BASE + 20'hC}));
        data_out = 32'h0000_0BAD; num_of_errors = 2'd3; operation_done = 1'b1;
        tick();
        operation_done = 1'b0;
        rsp_ready = 1'b0;
        ticks(3);
        data_out = 32'h0000_0777; num_of_errors = 2'd1; operation_done = 1'b1;
        tick();
        operation_done = 1'b0;
        data_out = 32'h5555_5555; num_of_errors = 2'd0;
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        push_exp(2'd0, 32'h0000_003C, 2'd0, 32'h0, 32'h0000_013C, 2'd0, 1'b0);
        cmd_valid = 1'b1; cmd_ctrl = 2'd0; cmd_data = 32'h0000_003C; cmd_width = 2'd0; cmd_noise = 32'h0;
        for (int i = 0; i < 10; i++) begin
            check("bp_cmd_ready", 64'({cmd_ready, rsp_valid}), 64'b01);
            tick();
        end
        rsp_ready = 1'b1;
        check("bp_still_valid", 64'({cmd_ready, rsp_valid}), 64'b01);
        tick();
        check("bp_release", 64'({cmd_ready, rsp_valid}), 64'b10);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_accept", 64'({PSEL, PENABLE, PADDR}), 64'({2'b10, BASE + 20'h4}));
        ticks(8);
        data_out = 32'h0000_013C; num_of_errors = 2'd0; operation_done = 1'b1;
        tick();
        operation_done = 1'b0;
        check("bp_next_rsp", 64'(rsp_valid), 64'd1);
        tick();

        // Reset during NOISE ACCESS
        send_cmd(2'd2, 32'h0000_0099, 2'd1, 32'h0000_0002, 32'h0, 2'd0, 1'b0);
        ticks(5);
        check("rst_noise_access", 64'({PSEL, PENABLE, PADDR}), 64'({2'b11, BASE + 20'hC}));
        #2 rst = 1'b0;
        #1;
        check("rst_mid_apb", 64'({PSEL, PENABLE}), 64'd0);
        check("rst_mid_ctl", 64'({cmd_ready, busy, rsp_valid}), 64'd0);
        exp_apb.delete();
        exp_rsp.delete();
        ticks(2);
        rst = 1'b1;
        check("rst2_cmd_ready_lo", 64'(cmd_ready), 64'd0);
        tick();
        check("rst2_cmd_ready_hi", 64'(cmd_ready), 64'd1);
        ticks(15);
        check("rst2_no_rsp", 64'({rsp_valid, busy}), 64'd0);

        // Recovery after reset
        send_cmd(2'd0, 32'h0000_00A5, 2'd0, 32'h0, 32'h0000_01A5, 2'd0, 1'b0);
        ticks(10);
        data_out = 32'h0000_01A5; num_of_errors = 2'd0; operation_done = 1'b1;
        tick();
        operation_done = 1'b0;
        check("rec_rsp_valid", 64'(rsp_valid), 64'd1);
        ticks(3);

        check("apb_queue_empty", 64'(exp_apb.size()), 64'd0);
        check("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
